// File: rtl/pipe_ctrl_v2.sv
// pipe_ctrl_v2: pipeline control for redirect, hold and flush.
// Collects hold requests, delivers jump redirects to pc_reg (parking one that
// cannot be accepted yet), generates per-stage flush pulses, and runs a hold
// watchdog. Optional performance counters are built only when the macro
// PIPE_CTRL_PERF_EN is defined; otherwise their ports read as zero.
//
// Redirect handshake: jump_en_o is the valid and if_ready_i the ready. A
// redirect transfers in any cycle where both are 1. While valid is high and
// ready is low, the redirect is parked in pend_q/pend_addr_q and presented
// unchanged until it is accepted. A new jump_en_i arriving while one is
// parked is dropped and latches err_o.
module pipe_ctrl_v2 #(
   parameter int XLEN         = 32,
   parameter int NUM_HOLD     = 4,
   parameter int NUM_STAGES   = 3,
   parameter int FLUSH_CYCLES = 1,
   parameter int HOLD_TIMEOUT = 1024,
   localparam int HS_W        = (NUM_HOLD > 1) ? $clog2(NUM_HOLD) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  jump_en_i,
   input  logic [XLEN-1:0]       jump_addr_i,
   input  logic [NUM_HOLD-1:0]   hold_req_i,
   input  logic                  if_ready_i,
   output logic                  jump_en_o,
   output logic [XLEN-1:0]       jump_addr_o,
   output logic                  hold_o,
   output logic [NUM_STAGES-1:0] flush_o,
   output logic [HS_W-1:0]       hold_src_o,
   output logic                  timeout_o,
   output logic                  err_o,
   output logic [31:0]           stall_cnt_o,
   output logic [31:0]           flush_cnt_o
);

   localparam int WD_W = $clog2(HOLD_TIMEOUT + 1);

   logic            pend_q;
   logic [XLEN-1:0] pend_addr_q;
   logic [3:0]      flush_cnt_q;
   logic [WD_W-1:0] wd_q;
   logic            accept;
   logic            flush_active;

   // A parked redirect always takes precedence over a fresh request.
   assign jump_en_o    = pend_q | jump_en_i;
   assign jump_addr_o  = pend_q ? pend_addr_q : jump_addr_i;
   assign accept       = jump_en_o & if_ready_i;
   assign flush_active = (flush_cnt_q != 4'd0);
   assign flush_o      = (accept | flush_active) ? {NUM_STAGES{1'b1}} : {NUM_STAGES{1'b0}};
   assign hold_o       = (|hold_req_i) | jump_en_o | flush_active;

   // Lowest-numbered active hold source wins; zero when nothing requests.
   always_comb begin
      hold_src_o = '0;
      for (int i = NUM_HOLD - 1; i >= 0; i--) begin
         if (hold_req_i[i]) hold_src_o = HS_W'(i);
      end
   end

   // Park an unaccepted redirect; the parked target is frozen until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
      end else if (accept) begin
         pend_q <= 1'b0;
      end else if (!pend_q && jump_en_i) begin
         pend_q      <= 1'b1;
         pend_addr_q <= jump_addr_i;
      end
   end

   // Sticky error: a new request arrived while one was already parked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_o <= 1'b0;
      end else if (pend_q && jump_en_i) begin
         err_o <= 1'b1;
      end
   end

   // Flush length counter; an acceptance restarts the full pulse length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_cnt_q <= 4'd0;
      end else if (accept) begin
         flush_cnt_q <= 4'(FLUSH_CYCLES);
      end else if (flush_active) begin
         flush_cnt_q <= flush_cnt_q - 4'd1;
      end
   end

   // Watchdog over consecutive hold cycles; pulses and restarts at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q      <= '0;
         timeout_o <= 1'b0;
      end else if (!hold_o) begin
         wd_q      <= '0;
         timeout_o <= 1'b0;
      end else if (wd_q == WD_W'(HOLD_TIMEOUT - 1)) begin
         wd_q      <= '0;
         timeout_o <= 1'b1;
      end else begin
         wd_q      <= wd_q + 1'b1;
         timeout_o <= 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   // Saturating performance counters: hold cycles and accepted redirects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else begin
         if (hold_o && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
         if (accept && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
   assign flush_cnt_o = flush_q;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Testbench for pipe_ctrl_v2 with FLUSH_CYCLES=2 and HOLD_TIMEOUT=4.
// A cycle-level reference model predicts every output from the redirect,
// flush, hold and watchdog rules; a queue tracks redirect targets that must
// reach pc_reg, in order, with dropped requests excluded.
module tb_pipe_ctrl_v2;

   localparam int XLEN   = 32;
   localparam int NH     = 4;
   localparam int NS     = 3;
   localparam int FLUSH  = 2;
   localparam int TMO    = 4;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF   = 1'b1;
`else
   localparam bit PERF   = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            jump_en_i;
   logic [XLEN-1:0] jump_addr_i;
   logic [NH-1:0]   hold_req_i;
   logic            if_ready_i;
   logic            jump_en_o;
   logic [XLEN-1:0] jump_addr_o;
   logic            hold_o;
   logic [NS-1:0]   flush_o;
   logic [1:0]      hold_src_o;
   logic            timeout_o;
   logic            err_o;
   logic [31:0]     stall_cnt_o;
   logic [31:0]     flush_cnt_o;

   pipe_ctrl_v2 #(
      .XLEN(XLEN), .NUM_HOLD(NH), .NUM_STAGES(NS),
      .FLUSH_CYCLES(FLUSH), .HOLD_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .hold_req_i(hold_req_i), .if_ready_i(if_ready_i),
      .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
      .hold_o(hold_o), .flush_o(flush_o), .hold_src_o(hold_src_o),
      .timeout_o(timeout_o), .err_o(err_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   // ---------------- scoreboard / model state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [XLEN-1:0] exp_q[$];

   bit          m_pend;
   logic [31:0] m_pend_addr;
   int          m_flush_left;
   int          m_run;
   bit          m_err;
   bit          m_to;
   logic [31:0] m_stall;
   logic [31:0] m_flushc;

   task automatic model_reset();
      m_pend = 0; m_pend_addr = '0; m_flush_left = 0; m_run = 0;
      m_err = 0; m_to = 0; m_stall = '0; m_flushc = '0;
      exp_q.delete();
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Entered just after a rising edge; checks at the falling edge, then
   // advances the model and returns just after the next rising edge.
   task automatic cycle(input bit jen, input logic [31:0] addr,
                        input logic [3:0] hreq, input bit rdy);
      bit          e_jen, acc, e_hold, found;
      logic [31:0] e_addr, sb_addr;
      logic [2:0]  e_flush;
      logic [1:0]  e_src;
      jump_en_i = jen; jump_addr_i = addr; hold_req_i = hreq; if_ready_i = rdy;

      e_jen   = m_pend || jen;
      e_addr  = m_pend ? m_pend_addr : addr;
      acc     = e_jen && rdy;
      e_flush = (acc || m_flush_left > 0) ? 3'b111 : 3'b000;
      e_hold  = (hreq != 0) || e_jen || (m_flush_left > 0);
      e_src   = 2'd0; found = 0;
      for (int i = 0; i < NH; i++) begin
         if (!found && hreq[i]) begin e_src = 2'(i); found = 1; end
      end
      if (jen && !m_pend) exp_q.push_back(addr);

      @(negedge clk);
      n_checks++; if (jump_en_o !== e_jen) begin n_fail++; $display("FAIL jump_en_o got %0b want %0b t=%0t", jump_en_o, e_jen, $time); end
      n_checks++; if (jump_addr_o !== e_addr) begin n_fail++; $display("FAIL jump_addr_o got %h want %h t=%0t", jump_addr_o, e_addr, $time); end
      n_checks++; if (flush_o !== e_flush) begin n_fail++; $display("FAIL flush_o got %b want %b t=%0t", flush_o, e_flush, $time); end
      n_checks++; if (hold_o !== e_hold) begin n_fail++; $display("FAIL hold_o got %0b want %0b t=%0t", hold_o, e_hold, $time); end
      n_checks++; if (hold_src_o !== e_src) begin n_fail++; $display("FAIL hold_src_o got %0d want %0d t=%0t", hold_src_o, e_src, $time); end
      n_checks++; if (err_o !== m_err) begin n_fail++; $display("FAIL err_o got %0b want %0b t=%0t", err_o, m_err, $time); end
      n_checks++; if (timeout_o !== m_to) begin n_fail++; $display("FAIL timeout_o got %0b want %0b t=%0t", timeout_o, m_to, $time); end
      n_checks++; if (stall_cnt_o !== m_stall) begin n_fail++; $display("FAIL stall_cnt_o got %0d want %0d t=%0t", stall_cnt_o, m_stall, $time); end
      n_checks++; if (flush_cnt_o !== m_flushc) begin n_fail++; $display("FAIL flush_cnt_o got %0d want %0d t=%0t", flush_cnt_o, m_flushc, $time); end
      if (jump_en_o === 1'b1 && if_ready_i === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL sb_target got %h want <none> t=%0t", jump_addr_o, $time);
         end else begin
            sb_addr = exp_q.pop_front();
            if (jump_addr_o !== sb_addr) begin n_fail++; $display("FAIL sb_target got %h want %h t=%0t", jump_addr_o, sb_addr, $time); end
         end
      end

      // advance model across the rising edge
      if (m_pend && jen) m_err = 1;
      if (acc) begin
         m_pend = 0; m_flush_left = FLUSH;
         if (PERF && m_flushc != 32'hFFFF_FFFF) m_flushc = m_flushc + 1;
      end else begin
         if (e_jen) begin m_pend = 1; m_pend_addr = e_addr; end
         if (m_flush_left > 0) m_flush_left--;
      end
      if (PERF && e_hold && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (e_hold) begin
         m_run++;
         if (m_run == TMO) begin m_to = 1; m_run = 0; end
         else m_to = 0;
      end else begin
         m_run = 0; m_to = 0;
      end

      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 4'h0, 1'b1);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      jump_en_i = 0; jump_addr_i = '0; hold_req_i = '0; if_ready_i = 0;
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({jump_en_o, hold_o, flush_o, timeout_o, err_o} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0", {jump_en_o, hold_o, flush_o, timeout_o, err_o}); end
      n_checks++; if ({stall_cnt_o, flush_cnt_o} !== 64'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", {stall_cnt_o, flush_cnt_o}); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      idle(2);
   endtask

   task automatic test_jump_accept();
      cycle(1'b1, 32'h0000_0100, 4'h0, 1'b1);
      idle(4);
   endtask

   task automatic test_pending();
      cycle(1'b1, 32'h0000_0200, 4'h0, 1'b0);
      cycle(1'b0, 32'h0000_0000, 4'h0, 1'b0);
      cycle(1'b0, 32'h0000_0000, 4'h0, 1'b0);
      cycle(1'b0, 32'h0000_0000, 4'h0, 1'b1);
      idle(4);
   endtask

   task automatic test_drop();
      cycle(1'b1, 32'h0000_0200, 4'h0, 1'b0);
      cycle(1'b1, 32'h0000_0300, 4'h0, 1'b0);
      cycle(1'b0, 32'h0000_0000, 4'h0, 1'b0);
      cycle(1'b0, 32'h0000_0000, 4'h0, 1'b1);
      idle(5);
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 32'h0000_0100, 4'h0, 1'b1);
      cycle(1'b1, 32'h0000_0400, 4'h0, 1'b0);
      jump_en_i = 1; jump_addr_i = 32'h0000_0055; hold_req_i = '0; if_ready_i = 0;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (jump_en_o !== 1'b1 || jump_addr_o !== 32'h0000_0055) begin n_fail++; $display("FAIL rst_mid_redirect got %0b/%h want 1/00000055", jump_en_o, jump_addr_o); end
      n_checks++; if (flush_o !== 3'b000 || hold_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flush got %b/%0b want 000/1", flush_o, hold_o); end
      n_checks++; if (err_o !== 1'b0 || timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags got %0b/%0b want 0/0", err_o, timeout_o); end
      n_checks++; if ({stall_cnt_o, flush_cnt_o} !== 64'd0) begin n_fail++; $display("FAIL rst_mid_cnt got %h want 0", {stall_cnt_o, flush_cnt_o}); end
      jump_en_i = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      idle(2);
   endtask

   task automatic test_hold_src();
      cycle(1'b0, 32'h0, 4'b1010, 1'b1);
      cycle(1'b0, 32'h0, 4'b0000, 1'b1);
      cycle(1'b0, 32'h0, 4'b1000, 1'b1);
      cycle(1'b0, 32'h0, 4'b0111, 1'b1);
      idle(2);
   endtask

   task automatic test_watchdog();
      logic [9:0] seen;
      idle(3);
      seen = '0;
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 32'h0, (k < 9) ? 4'b0001 : 4'b0000, 1'b1);
         seen[k] = timeout_o;
      end
      n_checks++; if (seen !== 10'b00_1000_1000) begin n_fail++; $display("FAIL watchdog_pulses got %b want 0010001000", seen); end
   endtask

   task automatic test_stall_hold();
      for (int k = 0; k < 100; k++) cycle(1'b0, 32'h0, 4'b0100, 1'b1);
      idle(2);
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 3) == 0), $urandom,
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
               1'($urandom_range(0, 1)));
      end
      idle(5);
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain got %0d left want 0", exp_q.size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      model_reset();
      test_reset();
      test_jump_accept();
      test_pending();
      test_drop();
      test_reset_mid();
      test_hold_src();
      test_watchdog();
      test_stall_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
